// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage types and constants
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} ps_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: ready/valid pipeline register with 2-entry skid, flush and saturating stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    ps_state_t state, state_nx;
    logic [DATA_W-1:0] main_q, main_nx, skid_q, skid_nx;
    logic accept, pop;

    assign accept = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= PS_EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
            stall_cnt <= (out_valid && !out_ready && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
        end
    end

    // main_q is forced to BUBBLE on every path into EMPTY so out_data needs no gating
    always_comb begin
        state_nx = state;
        main_nx = main_q;
        skid_nx = skid_q;
        if (flush) begin
            state_nx = PS_EMPTY;
            main_nx = BUBBLE;
        end else begin
            case (state)
                PS_EMPTY: if (accept) begin
                    state_nx = PS_ONE;
                    main_nx = in_data;
                end
                PS_ONE: if (accept && pop) begin
                    main_nx = in_data;
                end else if (accept) begin
                    state_nx = PS_TWO;
                    skid_nx = in_data;
                end else if (pop) begin
                    state_nx = PS_EMPTY;
                    main_nx = BUBBLE;
                end
                PS_TWO: if (pop) begin
                    state_nx = PS_ONE;
                    main_nx = skid_q;
                end
                default: begin
                    state_nx = PS_EMPTY;
                    main_nx = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = state != PS_EMPTY;
        in_ready = state != PS_TWO;
        out_data = main_q;
    end
endmodule
